// File: rtl/imem_loadable.sv
// imem_loadable: loadable sync-read instruction memory (load port: load_en/load_valid/load_data; fetch port: pc/fetch_en -> out/out_valid/misaligned/out_of_range; status: busy/load_count)
module imem_loadable #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 64,
  parameter int ADDR_W = 6,
  parameter logic [DATA_W-1:0] NOP = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic [31:0]       pc,
  input  logic              fetch_en,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  output logic              misaligned,
  output logic              out_of_range,
  output logic              busy,
  output logic [ADDR_W:0]   load_count
);
  localparam logic [1:0] EMPTY = 2'd0, LOAD = 2'd1, RUN = 2'd2;
  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
  logic [1:0] state;
  logic lock, write, reload, mis, oor;
  logic [ADDR_W:0] cnt_nxt;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] mem [DEPTH];
  always_comb begin
    idx = pc[ADDR_W+1:2];
    write = state == LOAD && load_valid && load_count != FULL;
    cnt_nxt = load_count + (ADDR_W+1)'(write);
    reload = state == RUN && load_en && !lock;
    mis = pc[1:0] != 2'b00;
    oor = |pc[31:ADDR_W+2] || {1'b0, idx} >= load_count;
  end
  assign busy = state == LOAD;
  always_ff @(posedge clk)
    if (write) mem[load_count[ADDR_W-1:0]] <= load_data;
  // lock keeps a still-held load_en from restarting a load once memory filled up
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      load_count <= '0;
      lock <= 1'b0;
      out <= NOP;
      out_valid <= 1'b0;
      misaligned <= 1'b0;
      out_of_range <= 1'b0;
    end else begin
      lock <= load_en && (lock || (write && cnt_nxt == FULL));
      if (state == EMPTY && load_en) begin
        state <= LOAD;
        load_count <= '0;
      end
      if (state == LOAD) begin
        load_count <= cnt_nxt;
        state <= (cnt_nxt == FULL || (!load_en && cnt_nxt != '0)) ? RUN : load_en ? LOAD : EMPTY;
      end
      if (reload) begin
        state <= LOAD;
        load_count <= '0;
        out <= NOP;
        out_valid <= 1'b0;
        misaligned <= 1'b0;
        out_of_range <= 1'b0;
      end else if (state == RUN && fetch_en) begin
        out <= (mis || oor) ? NOP : mem[idx];
        out_valid <= !(mis || oor);
        misaligned <= mis;
        out_of_range <= oor;
      end
    end
  end
endmodule

// File: tb/tb_imem_loadable.sv
// tb_imem_loadable: directed and random checks of imem_loadable against a queue-based program model
module tb_imem_loadable;
  logic clk = 1'b0, rst = 1'b1, load_en = 1'b0, load_valid = 1'b0, fetch_en = 1'b0;
  logic [31:0] load_data = '0, pc = '0, out;
  logic out_valid, misaligned, out_of_range, busy;
  logic [6:0] load_count;
  int checks = 0, errors = 0;
  int mode = 0;
  bit hold = 1'b0;
  logic [31:0] prog [$];
  logic [31:0] e_out = '0;
  bit e_v = 1'b0, e_m = 1'b0, e_r = 1'b0;
  logic [31:0] w7 [7] = '{32'h34040050, 32'h8c880000, 32'h20840004, 32'h8c890000,
                          32'h01094020, 32'h20840004, 32'hac880000};
  logic [31:0] big [70];

  imem_loadable dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_valid(load_valid), .load_data(load_data),
    .pc(pc), .fetch_en(fetch_en), .out(out), .out_valid(out_valid), .misaligned(misaligned),
    .out_of_range(out_of_range), .busy(busy), .load_count(load_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // mode: 0 empty, 1 loading, 2 running; program is the queue of accepted words
  task automatic model();
    int idx;
    if (rst) begin
      mode = 0; prog.delete(); hold = 0; e_out = '0; e_v = 0; e_m = 0; e_r = 0;
    end else if (mode == 0) begin
      if (load_en) begin mode = 1; prog.delete(); end
    end else if (mode == 1) begin
      if (load_valid && prog.size() < 64) prog.push_back(load_data);
      if (prog.size() == 64) begin mode = 2; hold = load_en; end
      else if (!load_en) mode = prog.size() > 0 ? 2 : 0;
    end else if (load_en && !hold) begin
      mode = 1; prog.delete(); e_out = '0; e_v = 0; e_m = 0; e_r = 0;
    end else begin
      if (!load_en) hold = 0;
      if (fetch_en) begin
        idx = int'((pc >> 2) % 64);
        e_m = pc % 4 != 0;
        e_r = pc >= 256 || idx >= prog.size();
        e_v = !e_m && !e_r;
        e_out = e_v ? prog[idx] : '0;
      end
    end
  endtask

  task automatic cyc();
    model();
    @(posedge clk);
    #1;
    chk("out", out, e_out);
    chk("out_valid", 32'(out_valid), 32'(e_v));
    chk("misaligned", 32'(misaligned), 32'(e_m));
    chk("out_of_range", 32'(out_of_range), 32'(e_r));
    chk("busy", 32'(busy), 32'(mode == 1));
    chk("load_count", 32'(load_count), 32'(prog.size()));
  endtask

  initial begin
    cyc();
    cyc();
    rst = 0;
    chk("rst_out", out, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(load_count), 32'd0);
    fetch_en = 1; pc = 0;
    cyc();
    chk("empty_fetch_valid", 32'(out_valid), 32'd0);
    fetch_en = 0; load_en = 1;
    cyc();
    for (int i = 0; i < 7; i++) begin
      load_valid = 1; load_data = w7[i];
      cyc();
      chk("load7_busy", 32'(busy), 32'd1);
    end
    load_valid = 0; load_en = 0;
    cyc();
    chk("load7_count", 32'(load_count), 32'd7);
    chk("load7_run", 32'(busy), 32'd0);
    fetch_en = 1; pc = 32'h10;
    cyc();
    chk("fetch10", out, 32'h01094020);
    chk("fetch10_v", 32'(out_valid), 32'd1);
    for (int i = 0; i < 7; i++) begin
      fetch_en = 1; pc = 32'(i * 4);
      cyc();
      chk("seq", out, w7[i]);
      if (i == 2) begin
        fetch_en = 0; pc = 32'h14;
        repeat (3) begin
          cyc();
          chk("stall", out, 32'h20840004);
        end
      end
    end
    fetch_en = 1; pc = 32'h1c;
    cyc();
    chk("pc1c_oor", 32'(out_of_range), 32'd1);
    chk("pc1c_out", out, 32'h0);
    pc = 32'h100;
    cyc();
    chk("pc100_oor", 32'(out_of_range), 32'd1);
    pc = 32'h06;
    cyc();
    chk("pc06_mis", 32'(misaligned), 32'd1);
    chk("pc06_v", 32'(out_valid), 32'd0);
    pc = 32'h103;
    cyc();
    chk("pc103_both", {30'd0, misaligned, out_of_range}, 32'd3);
    for (int i = 0; i < 40; i++) begin
      fetch_en = ($urandom % 4) != 0;
      pc = ($urandom % 5 == 0) ? $urandom : $urandom % 40;
      cyc();
    end
    fetch_en = 1; pc = 0;
    cyc();
    chk("pre_reload_v", 32'(out_valid), 32'd1);
    load_en = 1; pc = 4;
    cyc();
    chk("reload_wins_v", 32'(out_valid), 32'd0);
    chk("reload_busy", 32'(busy), 32'd1);
    fetch_en = 0;
    for (int i = 0; i < 70; i++) begin
      big[i] = $urandom;
      load_valid = 1; load_data = big[i];
      cyc();
    end
    chk("ovf_count", 32'(load_count), 32'd64);
    chk("ovf_run", 32'(busy), 32'd0);
    load_valid = 0; fetch_en = 1; pc = 32'hfc;
    cyc();
    chk("ovf_held_fetch", out, big[63]);
    load_en = 0;
    cyc();
    chk("ovf_fetch_fc", out, big[63]);
    load_en = 1; fetch_en = 0;
    cyc();
    for (int i = 0; i < 3; i++) begin
      load_valid = 1; load_data = $urandom;
      cyc();
    end
    load_valid = 0; load_en = 0; rst = 1;
    cyc();
    rst = 0;
    chk("midload_rst_count", 32'(load_count), 32'd0);
    chk("midload_rst_busy", 32'(busy), 32'd0);
    load_en = 1;
    cyc();
    for (int i = 0; i < 2; i++) begin
      load_valid = 1; load_data = w7[i + 3];
      cyc();
    end
    load_valid = 0; load_en = 0;
    cyc();
    fetch_en = 1; pc = 32'h08;
    cyc();
    chk("two_pc08_oor", 32'(out_of_range), 32'd1);
    pc = 32'h04;
    cyc();
    chk("two_pc04", out, 32'h01094020);
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom % 80) == 0;
      load_en = ($urandom % 10) < 2;
      load_valid = $urandom % 2;
      load_data = $urandom;
      fetch_en = ($urandom % 4) != 0;
      pc = ($urandom % 6 == 0) ? $urandom : $urandom % 80;
      cyc();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
